// File: rtl/spi_rx_packer.sv
// Packs pairs of SPI-received bytes into 16-bit words and queues them in a
// small FIFO; flags dropped words (overflow) and odd-length frames (frame_err).
module spi_rx_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  output logic        frame_err
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B0 = 2'd1,
    WAIT_B1 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_hold;
  logic               w_hold_ld;
  logic               w_hold_clr;
  logic               w_push;
  logic               w_frame_err;
  logic [15:0]        w_word;

  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [4:0]         r_count;
  logic               r_overflow;
  logic               r_frame_err;

  logic               w_pop;
  logic               w_push_acc;
  logic               w_push_drop;

  // ---------------------------------------------------------------- packer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // cs high takes priority over a coincident byte_valid in every state
  always_comb begin
    w_state_nxt = r_state;
    w_hold_ld   = 1'b0;
    w_hold_clr  = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!cs) begin
          w_state_nxt = WAIT_B0;
        end
      end
      WAIT_B0: begin
        if (cs) begin
          w_state_nxt = IDLE;
        end else if (byte_valid) begin
          w_hold_ld   = 1'b1;
          w_state_nxt = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (cs) begin
          w_hold_clr  = 1'b1;
          w_frame_err = 1'b1;
          w_state_nxt = IDLE;
        end else if (byte_valid) begin
          w_push      = 1'b1;
          w_state_nxt = WAIT_B0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_hold_clr) begin
      r_hold <= '0;
    end else if (w_hold_ld) begin
      r_hold <= byte_in;
    end
  end

  assign w_word = MSB_FIRST ? {r_hold, byte_in} : {byte_in, r_hold};

  // ---------------------------------------------------------------- word FIFO
  assign w_pop       = (r_count != 5'd0) && word_ready;
  assign w_push_acc  = w_push && ((r_count < DEPTH_C) || w_pop);
  assign w_push_drop = w_push && !w_push_acc;

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overflow  <= w_push_drop;
      r_frame_err <= w_frame_err;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_acc && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_push_acc) begin
        r_count <= r_count - 5'd1;
      end
    end
  end

  // Memory is not reset, so the head is masked to zero while the FIFO is empty
  assign word_valid = (r_count != 5'd0);
  assign word_out   = word_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: doc/spi_rx_packer.md
SPI_RX_PACKER -- requirements
Module: spi_rx_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of 16-bit word entries (power of 2, range 2..16).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = first byte of a pair is word[15:8], 0 = first byte is word[7:0].
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cs  input  1  SPI chip select from the SPI master, active-low; low = frame in progress.
REQ-006 byte_valid  input  1  single-cycle pulse, the received byte is complete (the master's finished strobe).
REQ-007 byte_in  input  8  received byte, valid when byte_valid=1.
REQ-008 word_out  output  16  FIFO head word.
REQ-009 word_valid  output  1  FIFO non-empty; word_out is valid.
REQ-010 word_ready  input  1  consumer accepts word_out when word_valid & word_ready.
REQ-011 fifo_count  output  5  number of stored words, 0..FIFO_DEPTH.
REQ-012 overflow  output  1  one-cycle pulse, completed word dropped because FIFO full.
REQ-013 frame_err  output  1  one-cycle pulse, cs rose with an odd byte pending; partial byte discarded.

Function
REQ-014 The packer SHALL use states IDLE, WAIT_B0 and WAIT_B1.
REQ-015 IDLE -> WAIT_B0 SHALL occur on the first cycle cs=0; byte_valid in IDLE SHALL be ignored.
REQ-016 WAIT_B0 with byte_valid=1 SHALL latch byte_in into a holding register and go to WAIT_B1.
REQ-017 WAIT_B1 with byte_valid=1 SHALL form the word per MSB_FIRST, push it the same cycle, and return to WAIT_B0.
REQ-018 cs=1 in WAIT_B0 SHALL go to IDLE with no pulse; cs=1 in WAIT_B1 SHALL go to IDLE, discard the held byte and pulse frame_err for one cycle.
REQ-019 When cs=1 and byte_valid=1 occur in the same cycle, the byte SHALL be ignored and REQ-018 SHALL apply.
REQ-020 A pushed word SHALL appear at word_out with word_valid=1 on the cycle after the push when the FIFO was empty (1-cycle latency).
REQ-021 A pop SHALL occur on each cycle with word_valid=1 and word_ready=1; word_out SHALL advance to the next entry on the following cycle.
REQ-022 A push SHALL be accepted when fifo_count<FIFO_DEPTH, or when fifo_count=FIFO_DEPTH and a pop occurs in the same cycle.
REQ-023 A push not accepted under REQ-022 SHALL drop the word, leave FIFO contents unchanged and pulse overflow for one cycle.
REQ-024 Simultaneous accepted push and pop SHALL leave fifo_count unchanged.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-026 word_ready when word_valid=0 SHALL have no effect.
REQ-027 word_out SHALL hold its value while word_valid=1 and word_ready=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, holding register=0, pointers=0, fifo_count=0, word_valid=0, word_out=16'h0000, overflow=0 and frame_err=0.
REQ-029 Reset asserted mid-frame or with a non-empty FIFO SHALL discard all data, with no overflow or frame_err pulse on reset release.
REQ-030 After rst_n rises, a frame SHALL start only from a cs=0 observed in IDLE.

Verification
REQ-031 MSB_FIRST=1: cs=0, bytes 8'hA5 then 8'h3C, word_ready=1 -> word_out=16'hA53C, word_valid=1 for exactly 1 cycle, starting 1 cycle after the second byte.
REQ-032 MSB_FIRST=0: same bytes -> word_out=16'h3CA5.
REQ-033 word_ready=0, 5 words pushed with FIFO_DEPTH=4 -> fifo_count=4, overflow pulses once on the 5th push; draining returns words 1..4 in order.
REQ-034 cs rises after a single byte 8'h11 -> frame_err pulses once, no push; the next frame with 8'h22, 8'h33 yields 16'h2233.
REQ-035 FIFO full with push and pop in the same cycle -> no overflow, fifo_count stays 4, the new word ends up last in order.
REQ-036 rst_n pulsed low while in WAIT_B1 with 2 words stored -> fifo_count=0, word_valid=0 immediately; no pulses after release.
